// File: rtl/mcc_ctrl_pkg.sv
// Shared types and default sizing for the 2x2 MAC array sequencer.
package mcc_ctrl_pkg;

    localparam int DEF_DW      = 16;
    localparam int DEF_OW      = 26;
    localparam int DEF_KW      = 8;
    localparam int DEF_MCC_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/mcc2x2_ctrl.sv
// Sequencer for the mcc2x2 array: clears the accumulators, streams a
// programmed number of operand beats into the array, waits out the array
// latency, then holds the four results on a valid/ready handshake.
module mcc2x2_ctrl
    import mcc_ctrl_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int OW      = DEF_OW,
    parameter int KW      = DEF_KW,
    parameter int MCC_LAT = DEF_MCC_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] cfg_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_i0,
    input  logic [DW-1:0] in_i1,
    input  logic [DW-1:0] in_w0,
    input  logic [DW-1:0] in_w1,
    output logic          mcc_clr,
    output logic [DW-1:0] mcc_i0,
    output logic [DW-1:0] mcc_i1,
    output logic [DW-1:0] mcc_w0,
    output logic [DW-1:0] mcc_w1,
    input  logic [OW-1:0] mcc_o0,
    input  logic [OW-1:0] mcc_o1,
    input  logic [OW-1:0] mcc_o2,
    input  logic [OW-1:0] mcc_o3,
    output logic [OW-1:0] res0,
    output logic [OW-1:0] res1,
    output logic [OW-1:0] res2,
    output logic [OW-1:0] res3,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic [KW-1:0] skip_cnt
);

    // Drain counter runs 0..MCC_LAT, i.e. MCC_LAT+1 cycles.
    localparam int              DCW        = $clog2(MCC_LAT + 2);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(MCC_LAT);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [KW-1:0]   r_len;
    logic [KW-1:0]   r_cnt;
    logic [KW-1:0]   r_skip;
    logic [DCW-1:0]  r_drain;

    logic [DW-1:0]   r_mcc_i0;
    logic [DW-1:0]   r_mcc_i1;
    logic [DW-1:0]   r_mcc_w0;
    logic [DW-1:0]   r_mcc_w1;

    logic [OW-1:0]   r_res0;
    logic [OW-1:0]   r_res1;
    logic [OW-1:0]   r_res2;
    logic [OW-1:0]   r_res3;

    logic            w_start;
    logic            w_cap;
    logic            w_xfer;
    logic            w_skip_beat;
    logic [KW-1:0]   w_cnt_inc;

    assign w_xfer      = in_valid && in_ready;
    assign w_cnt_inc   = r_cnt + KW'(1);
    assign w_skip_beat = ((in_i0 == '0) && (in_i1 == '0)) ||
                         ((in_w0 == '0) && (in_w1 == '0));

    // The array's reset pins follow our own reset immediately, so an abort
    // clears the accumulators in the same cycle.
    assign mcc_clr = reset | (r_state == CLEAR);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        w_start     = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start     = 1'b1;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_state_nxt = (r_len != '0) ? RUN : DRAIN;
            end
            RUN: begin
                in_ready = 1'b1;
                // Leave RUN on the beat that brings the count to len, so the
                // counter stops there and never wraps.
                if (in_valid && (w_cnt_inc == r_len)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_cap       = 1'b1;
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Tile length, beat counter and zero-skip counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_skip <= '0;
        end else if (w_start) begin
            r_len  <= cfg_len;
            r_cnt  <= '0;
            r_skip <= '0;
        end else if (w_xfer) begin
            r_cnt <= w_cnt_inc;
            if (w_skip_beat) r_skip <= r_skip + KW'(1);
        end
    end

    // Drain timer: counts only while waiting out the array latency.
    always_ff @(posedge clk) begin
        if (reset)                 r_drain <= '0;
        else if (r_state == DRAIN) r_drain <= r_drain + DCW'(1);
        else                       r_drain <= '0;
    end

    // Array operand registers: the accepted beat, otherwise zero so the
    // array holds its accumulators.
    always_ff @(posedge clk) begin
        if (reset || !w_xfer) begin
            r_mcc_i0 <= '0;
            r_mcc_i1 <= '0;
            r_mcc_w0 <= '0;
            r_mcc_w1 <= '0;
        end else begin
            r_mcc_i0 <= in_i0;
            r_mcc_i1 <= in_i1;
            r_mcc_w0 <= in_w0;
            r_mcc_w1 <= in_w1;
        end
    end

    // Result capture at the end of DRAIN; held stable through OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res0 <= '0;
            r_res1 <= '0;
            r_res2 <= '0;
            r_res3 <= '0;
        end else if (w_cap) begin
            r_res0 <= mcc_o0;
            r_res1 <= mcc_o1;
            r_res2 <= mcc_o2;
            r_res3 <= mcc_o3;
        end
    end

    assign mcc_i0   = r_mcc_i0;
    assign mcc_i1   = r_mcc_i1;
    assign mcc_w0   = r_mcc_w0;
    assign mcc_w1   = r_mcc_w1;
    assign res0     = r_res0;
    assign res1     = r_res1;
    assign res2     = r_res2;
    assign res3     = r_res3;
    assign skip_cnt = r_skip;

endmodule

// File: tb/tb_mcc2x2_ctrl.sv
// Self-checking bench for mcc2x2_ctrl with a behavioural 2x2 MAC array model.
module tb_mcc2x2_ctrl;

    localparam int DW  = 16;
    localparam int OW  = 26;
    localparam int KW  = 8;
    localparam int LAT = 2;

    typedef struct packed {
        logic [DW-1:0] i0;
        logic [DW-1:0] i1;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] cfg_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_i0, in_i1, in_w0, in_w1;
    logic          mcc_clr;
    logic [DW-1:0] mcc_i0, mcc_i1, mcc_w0, mcc_w1;
    logic [OW-1:0] mcc_o0, mcc_o1, mcc_o2, mcc_o3;
    logic [OW-1:0] res0, res1, res2, res3;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic [KW-1:0] skip_cnt;

    int            n_cmp = 0;
    int            n_err = 0;

    beat_t         beats[$];
    logic [OW-1:0] got_res[4];
    logic [OW-1:0] exp_res[4];
    logic [KW-1:0] got_skip;
    logic [KW-1:0] exp_skip;
    int            got_lat;
    int            got_bub;

    mcc2x2_ctrl #(.DW(DW), .OW(OW), .KW(KW), .MCC_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_i0(in_i0), .in_i1(in_i1), .in_w0(in_w0), .in_w1(in_w1),
        .mcc_clr(mcc_clr),
        .mcc_i0(mcc_i0), .mcc_i1(mcc_i1), .mcc_w0(mcc_w0), .mcc_w1(mcc_w1),
        .mcc_o0(mcc_o0), .mcc_o1(mcc_o1), .mcc_o2(mcc_o2), .mcc_o3(mcc_o3),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    // Array model: operands accumulate one cycle after they are presented,
    // then an output register adds a second cycle (LAT = 2).
    logic [OW-1:0] a_acc[4];
    logic [OW-1:0] a_out[4];

    always @(posedge clk) begin
        if (mcc_clr) begin
            for (int j = 0; j < 4; j++) begin
                a_acc[j] <= '0;
                a_out[j] <= '0;
            end
        end else begin
            a_acc[0] <= a_acc[0] + OW'(32'(mcc_i0) * 32'(mcc_w0));
            a_acc[1] <= a_acc[1] + OW'(32'(mcc_i0) * 32'(mcc_w1));
            a_acc[2] <= a_acc[2] + OW'(32'(mcc_i1) * 32'(mcc_w0));
            a_acc[3] <= a_acc[3] + OW'(32'(mcc_i1) * 32'(mcc_w1));
            for (int j = 0; j < 4; j++) a_out[j] <= a_acc[j];
        end
    end

    assign mcc_o0 = a_out[0];
    assign mcc_o1 = a_out[1];
    assign mcc_o2 = a_out[2];
    assign mcc_o3 = a_out[3];

    // Reference: results are plain dot-product sums over the tile, modulo 2^OW.
    task automatic model_tile(input int len);
        longint s[4];
        int     sk;
        for (int j = 0; j < 4; j++) s[j] = 0;
        sk = 0;
        for (int k = 0; k < len; k++) begin
            s[0] += longint'(beats[k].i0) * longint'(beats[k].w0);
            s[1] += longint'(beats[k].i0) * longint'(beats[k].w1);
            s[2] += longint'(beats[k].i1) * longint'(beats[k].w0);
            s[3] += longint'(beats[k].i1) * longint'(beats[k].w1);
            if ((beats[k].i0 == 0 && beats[k].i1 == 0) ||
                (beats[k].w0 == 0 && beats[k].w1 == 0)) sk++;
        end
        for (int j = 0; j < 4; j++) exp_res[j] = s[j][OW-1:0];
        exp_skip = KW'(sk);
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.i0 = DW'($urandom_range(0, 65535));
        b.i1 = DW'($urandom_range(0, 65535));
        b.w0 = DW'($urandom_range(0, 65535));
        b.w1 = DW'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) begin b.i0 = '0; b.i1 = '0; end
        if ($urandom_range(0, 3) == 0) begin b.w0 = '0; b.w1 = '0; end
        return b;
    endfunction

    // Drives one tile from the beats queue. bub_mode: 0 none, 1 alternate,
    // 2 random. hold = cycles res_ready stays low; poke drives start and
    // in_valid during OUT to prove they are ignored.
    task automatic run_tile(input int len, input int bub_mode, input int hold, input bit poke);
        int    idx, cyc;
        bit    done, v, pend_v;
        beat_t pend, junk, exp_m;
        idx = 0; cyc = 0; done = 0; pend_v = 0; got_bub = 0; pend = '0;
        @(negedge clk);
        start = 1'b1; cfg_len = KW'(len); in_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        n_cmp++;
        if (busy !== 1'b1 || mcc_clr !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_cycle: busy=%b mcc_clr=%b in_ready=%b, want 1/1/0", busy, mcc_clr, in_ready);
        end
        while (!done) begin
            exp_m = pend_v ? pend : '0;
            n_cmp++;
            if ({mcc_i0, mcc_i1, mcc_w0, mcc_w1} !== exp_m) begin
                n_err++;
                $display("FAIL operand_reg cyc %0d: got %h want %h", cyc,
                         {mcc_i0, mcc_i1, mcc_w0, mcc_w1}, exp_m);
            end
            pend_v = 0;
            if (res_valid === 1'b1) begin
                done = 1;
            end else if (cyc >= 2000) begin
                n_cmp++; n_err++;
                $display("FAIL res_valid_timeout: got no res_valid, want one within 2000 cycles");
                done = 1;
            end else begin
                if (idx < len) begin
                    case (bub_mode)
                        1:       v = (cyc % 2) == 1;
                        2:       v = $urandom_range(0, 2) != 0;
                        default: v = 1'b1;
                    endcase
                    junk = v ? beats[idx] : rand_beat();
                end else begin
                    // Tile complete: offer junk to tempt an extra accept.
                    v = 1'b1;
                    junk = rand_beat();
                end
                in_valid = v;
                {in_i0, in_i1, in_w0, in_w1} = junk;
                if (in_ready === 1'b1 && idx < len) begin
                    if (v) begin pend = beats[idx]; pend_v = 1; idx++; end
                    else   got_bub++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        got_lat = cyc;
        got_res[0] = res0; got_res[1] = res1; got_res[2] = res2; got_res[3] = res3;
        got_skip = skip_cnt;
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start     = poke;
            cfg_len   = 8'd5;
            in_valid  = poke;
            @(negedge clk);
            n_cmp++;
            if ({res0, res1, res2, res3} !== {got_res[0], got_res[1], got_res[2], got_res[3]} ||
                res_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                {mcc_i0, mcc_i1, mcc_w0, mcc_w1} !== '0) begin
                n_err++;
                $display("FAIL out_hold %0d: res_valid=%b in_ready=%b busy=%b res=%h/%h/%h/%h want held %h/%h/%h/%h",
                         h, res_valid, in_ready, busy, res0, res1, res2, res3,
                         got_res[0], got_res[1], got_res[2], got_res[3]);
            end
        end
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL out_release: res_valid=%b busy=%b, want 0/0", res_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; res_ready = 1'b0;
        in_i0 = '0; in_i1 = '0; in_w0 = '0; in_w1 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mcc_clr !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
            {mcc_i0, mcc_i1, mcc_w0, mcc_w1} !== '0 || {res0, res1, res2, res3} !== '0 ||
            skip_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_values: clr=%b rdy=%b busy=%b rv=%b skip=%0d, want 1/0/0/0/0",
                     mcc_clr, in_ready, busy, res_valid, skip_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mcc_clr !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: mcc_clr=%b busy=%b, want 0/0", mcc_clr, busy);
        end
    endtask

    task automatic test_basic();
        beats = {};
        beats.push_back({16'd1, 16'd2, 16'd3, 16'd4});
        beats.push_back({16'd5, 16'd6, 16'd7, 16'd8});
        beats.push_back({16'd2, 16'd0, 16'd1, 16'd1});
        run_tile(3, 0, 0, 0);
        model_tile(3);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_res[j] !== exp_res[j]) begin
                n_err++;
                $display("FAIL basic_res%0d: got %0d want %0d", j, got_res[j], exp_res[j]);
            end
        end
        n_cmp++;
        if (got_skip !== exp_skip) begin
            n_err++; $display("FAIL basic_skip: got %0d want %0d", got_skip, exp_skip);
        end
        n_cmp++;
        if (got_lat != 3 + LAT + 3) begin
            n_err++; $display("FAIL basic_latency: got %0d want %0d", got_lat, 3 + LAT + 3);
        end
    endtask

    task automatic test_bubbles();
        run_tile(3, 1, 0, 0);
        model_tile(3);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_res[j] !== exp_res[j]) begin
                n_err++;
                $display("FAIL bubble_res%0d: got %0d want %0d", j, got_res[j], exp_res[j]);
            end
        end
        n_cmp++;
        if (got_lat != 3 + LAT + 3 + got_bub) begin
            n_err++;
            $display("FAIL bubble_latency: got %0d want %0d", got_lat, 3 + LAT + 3 + got_bub);
        end
    endtask

    task automatic test_skip();
        beats = {};
        beats.push_back({16'd0, 16'd0, 16'd9, 16'd9});
        beats.push_back({16'd1, 16'd1, 16'd0, 16'd0});
        beats.push_back({16'd1, 16'd1, 16'd1, 16'd1});
        beats.push_back({16'd2, 16'd0, 16'd2, 16'd0});
        run_tile(4, 0, 0, 0);
        model_tile(4);
        n_cmp++;
        if (got_skip !== exp_skip) begin
            n_err++; $display("FAIL skip_count: got %0d want %0d", got_skip, exp_skip);
        end
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_res[j] !== exp_res[j]) begin
                n_err++;
                $display("FAIL skip_res%0d: got %0d want %0d", j, got_res[j], exp_res[j]);
            end
        end
    endtask

    task automatic test_len0();
        run_tile(0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_res[j] !== '0) begin
                n_err++; $display("FAIL len0_res%0d: got %0d want 0", j, got_res[j]);
            end
        end
        n_cmp++;
        if (got_lat != LAT + 3 || got_skip !== '0) begin
            n_err++;
            $display("FAIL len0_latency_skip: got lat %0d skip %0d want lat %0d skip 0",
                     got_lat, got_skip, LAT + 3);
        end
    endtask

    task automatic test_backpressure();
        beats = {};
        for (int k = 0; k < 3; k++) beats.push_back(rand_beat());
        run_tile(3, 0, 5, 1);
        model_tile(3);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_res[j] !== exp_res[j]) begin
                n_err++;
                $display("FAIL bp_res%0d: got %0d want %0d", j, got_res[j], exp_res[j]);
            end
        end
        // The start pulses during OUT must not have launched a tile.
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL bp_start_ignored: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        beats = {};
        for (int k = 0; k < 5; k++) beats.push_back({16'd3, 16'd5, 16'd7, 16'd9});
        @(negedge clk);
        start = 1'b1; cfg_len = 8'd5; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            {in_i0, in_i1, in_w0, in_w1} = beats[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mcc_clr !== 1'b1) begin
            n_err++; $display("FAIL abort_clr_same_cycle: mcc_clr=%b want 1", mcc_clr);
        end
        @(negedge clk);
        n_cmp++;
        if (mcc_clr !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
            {mcc_i0, mcc_i1, mcc_w0, mcc_w1} !== '0 || {res0, res1, res2, res3} !== '0 ||
            skip_cnt !== '0) begin
            n_err++;
            $display("FAIL abort_reset_values: clr=%b rdy=%b busy=%b rv=%b res0=%0d skip=%0d",
                     mcc_clr, in_ready, busy, res_valid, res0, skip_cnt);
        end
        reset = 1'b0;
        beats = {};
        beats.push_back({16'd1, 16'd1, 16'd1, 16'd1});
        run_tile(1, 0, 0, 0);
        model_tile(1);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_res[j] !== exp_res[j]) begin
                n_err++;
                $display("FAIL abort_fresh_res%0d: got %0d want %0d", j, got_res[j], exp_res[j]);
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(1, 12);
            beats = {};
            for (int k = 0; k < len; k++) beats.push_back(rand_beat());
            run_tile(len, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            model_tile(len);
            for (int j = 0; j < 4; j++) begin
                n_cmp++;
                if (got_res[j] !== exp_res[j]) begin
                    n_err++;
                    $display("FAIL rand%0d_res%0d: got %h want %h", t, j, got_res[j], exp_res[j]);
                end
            end
            n_cmp++;
            if (got_skip !== exp_skip || got_lat != len + LAT + 3 + got_bub) begin
                n_err++;
                $display("FAIL rand%0d_skip_lat: got skip %0d lat %0d want skip %0d lat %0d",
                         t, got_skip, got_lat, exp_skip, len + LAT + 3 + got_bub);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_skip();
        test_len0();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
